// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared widths, defaults and FSM encoding for the DRAM read arbiter
package dram_arb_pkg;
   localparam int ADDR_W = 40;
   localparam int DATA_W = 1024;
   localparam int NREQ_DEF = 4;
   localparam int TIMEOUT_DEF = 1023;
   localparam int CNT_W = 16;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/dram_read_arbiter_rr_pick.sv
// rr_pick: round-robin selection, searching from one past the last served requester
module rr_pick import dram_arb_pkg::*; #(
   parameter int NREQ = NREQ_DEF,
   parameter int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] win,
   output logic [IW-1:0]   idx,
   output logic            any
);
   logic [IW-1:0] j;
   always_comb begin
      win = '0;
      idx = '0;
      any = 1'b0;
      j = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = IW'((int'(last) + k) % NREQ);
         if (!any && req[j]) begin
            any = 1'b1;
            idx = j;
            win[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/dram_read_arbiter.sv
// dram_read_arbiter: round-robin arbiter sharing one DRAM read port among NREQ requesters,
// with a per-transaction timeout guarding against a memory that never answers.
module dram_read_arbiter import dram_arb_pkg::*; #(
   parameter int NREQ = NREQ_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [ADDR_W*NREQ-1:0] req_addr,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rvalid,
   output logic [DATA_W-1:0]      rdata,
   output logic                   timeout_err,
   output logic                   busy,
   output logic                   Renable,
   output logic [ADDR_W-1:0]      Raddr,
   input  logic                   Rready,
   input  logic [DATA_W-1:0]      Rdata
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [IW-1:0] last, last_n, cur, cur_n;
   logic [NREQ-1:0] gnt_n, rvalid_n, pick_win;
   logic [DATA_W-1:0] rdata_n;
   logic [ADDR_W-1:0] raddr_n, pick_addr;
   logic [IW-1:0] pick_idx;
   logic ren_n, terr_n, busy_n, pick_any;
   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req  (req),
      .last (last),
      .win  (pick_win),
      .idx  (pick_idx),
      .any  (pick_any)
   );
   always_comb begin
      pick_addr = '0;
      for (int i = 0; i < NREQ; i++)
         pick_addr = pick_addr | (pick_win[i] ? req_addr[i*ADDR_W +: ADDR_W] : '0);
   end
   // Rready is tested before the timeout so a late answer on the final cycle still counts.
   always_comb begin
      state_n = state;
      gnt_n = gnt;
      ren_n = Renable;
      raddr_n = Raddr;
      rdata_n = rdata;
      rvalid_n = '0;
      terr_n = 1'b0;
      cnt_n = cnt;
      last_n = last;
      cur_n = cur;
      case (state)
         S_IDLE: if (pick_any) begin
            state_n = S_WAIT;
            ren_n = 1'b1;
            raddr_n = pick_addr;
            gnt_n = pick_win;
            cur_n = pick_idx;
            cnt_n = '0;
         end
         S_WAIT: if (Rready || cnt == CNT_MAX) begin
            state_n = S_DONE;
            ren_n = 1'b0;
            gnt_n = '0;
            last_n = cur;
            rvalid_n = Rready ? gnt : '0;
            terr_n = !Rready;
            rdata_n = Rready ? Rdata : rdata;
         end else cnt_n = cnt + 1'b1;
         default: state_n = S_IDLE;
      endcase
      busy_n = state_n != S_IDLE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         gnt <= '0;
         Renable <= 1'b0;
         Raddr <= '0;
         rdata <= '0;
         rvalid <= '0;
         timeout_err <= 1'b0;
         busy <= 1'b0;
         cnt <= '0;
         last <= IW'(NREQ - 1);
         cur <= '0;
      end else begin
         state <= state_n;
         gnt <= gnt_n;
         Renable <= ren_n;
         Raddr <= raddr_n;
         rdata <= rdata_n;
         rvalid <= rvalid_n;
         timeout_err <= terr_n;
         busy <= busy_n;
         cnt <= cnt_n;
         last <= last_n;
         cur <= cur_n;
      end
   end
endmodule

// File: tb/tb_dram_read_arbiter.sv
// tb_dram_read_arbiter: randomized scenario bench for dram_read_arbiter against a
// transaction-level model (last-served index, expected winner, expected line).
module tb_dram_read_arbiter;
   import dram_arb_pkg::*;
   localparam int N = 4;
   localparam int TO = 1023;
   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] req, gnt, rvalid;
   logic [ADDR_W*N-1:0] req_addr;
   logic [DATA_W-1:0] rdata, Rdata;
   logic timeout_err, busy, Renable, Rready;
   logic [ADDR_W-1:0] Raddr;
   int checks = 0;
   int errors = 0;
   longint cyc = 0;
   int exp_last;
   logic [DATA_W-1:0] exp_rdata;
   logic [ADDR_W-1:0] addr_q [N];
   logic [N-1:0] o_gnt, o_gnt2, o_rvalid, o_rvalid2;
   logic [ADDR_W-1:0] o_raddr;
   logic [DATA_W-1:0] o_rdata;
   logic o_ren, o_ren2, o_stable, o_terr, o_rv_early, o_busy2;
   longint o_rise;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dram_read_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt), .rvalid(rvalid),
      .rdata(rdata), .timeout_err(timeout_err), .busy(busy), .Renable(Renable),
      .Raddr(Raddr), .Rready(Rready), .Rdata(Rdata)
   );

   function automatic logic [DATA_W-1:0] rand_line();
      logic [DATA_W-1:0] v;
      for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [ADDR_W-1:0] rand_addr();
      return {8'($urandom), $urandom};
   endfunction

   // next requester to serve: first set bit scanning upward from last+1, wrapping
   function automatic int rr_model(input logic [N-1:0] m, input int last);
      for (int k = 1; k <= N; k++) if (m[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   // starts at a negedge with the DUT idle; returns at the negedge after DONE
   task automatic do_txn(input logic [N-1:0] mask, input int delay, input bit drop,
                         input logic [DATA_W-1:0] line);
      req = mask;
      Rready = 1'b0;
      for (int i = 0; i < N; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_q[i];
      @(negedge clk);
      o_ren = Renable; o_gnt = gnt; o_raddr = Raddr; o_rise = cyc;
      o_stable = 1'b1; o_terr = 1'b0; o_rv_early = 1'b0;
      for (int d = 0; d < delay; d++) begin
         for (int i = 0; i < N; i++) req_addr[i*ADDR_W +: ADDR_W] = rand_addr();
         @(negedge clk);
         if (!(Renable === 1'b1 && Raddr === o_raddr && gnt === o_gnt)) o_stable = 1'b0;
         o_terr = o_terr | timeout_err;
         o_rv_early = o_rv_early | (|rvalid);
      end
      Rready = 1'b1;
      Rdata = line;
      @(negedge clk);
      o_rvalid = rvalid; o_rdata = rdata; o_ren2 = Renable; o_gnt2 = gnt;
      o_terr = o_terr | timeout_err;
      Rready = 1'b0;
      Rdata = rand_line();
      if (drop) req = req & ~o_gnt;
      @(negedge clk);
      o_rvalid2 = rvalid; o_busy2 = busy;
   endtask

   task automatic test_reset();
      rst = 1'b0; req = '0; req_addr = '0; Rready = 1'b0; Rdata = '0;
      repeat (2) @(negedge clk);
      checks++; if ({gnt, rvalid, timeout_err, busy, Renable} !== '0) begin errors++; $display("FAIL reset_ctrl got %b want 0", {gnt, rvalid, timeout_err, busy, Renable}); end
      checks++; if (Raddr !== '0) begin errors++; $display("FAIL reset_raddr got %h want 0", Raddr); end
      checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata[63:0]); end
      rst = 1'b1; exp_last = N - 1; exp_rdata = '0;
   endtask

   task automatic test_single();
      logic [DATA_W-1:0] a;
      a = rand_line();
      for (int i = 0; i < N; i++) addr_q[i] = rand_addr();
      addr_q[0] = 40'h40;
      do_txn(4'b0001, 4, 1'b1, a);
      checks++; if (o_ren !== 1'b1) begin errors++; $display("FAIL single_latency Renable got %b want 1", o_ren); end
      checks++; if (o_raddr !== 40'h40) begin errors++; $display("FAIL single_raddr got %h want 40", o_raddr); end
      checks++; if (o_gnt !== 4'b0001 || !o_stable) begin errors++; $display("FAIL single_gnt got %b stable %b want 0001 stable 1", o_gnt, o_stable); end
      checks++; if (o_rvalid !== 4'b0001 || o_rv_early) begin errors++; $display("FAIL single_rvalid got %b early %b want 0001", o_rvalid, o_rv_early); end
      checks++; if (o_rdata !== a) begin errors++; $display("FAIL single_rdata got %h want %h", o_rdata[63:0], a[63:0]); end
      checks++; if (o_ren2 || o_gnt2 !== '0 || o_terr) begin errors++; $display("FAIL single_release ren %b gnt %b terr %b want 0", o_ren2, o_gnt2, o_terr); end
      checks++; if (o_rvalid2 !== '0 || o_busy2) begin errors++; $display("FAIL single_done rvalid %b busy %b want 0 0", o_rvalid2, o_busy2); end
      exp_last = 0; exp_rdata = a;
   endtask

   task automatic test_round_robin();
      logic [N-1:0] want;
      logic [DATA_W-1:0] line;
      int w;
      rst = 1'b0; req = '0;
      @(negedge clk);
      rst = 1'b1; exp_last = N - 1; exp_rdata = '0;
      for (int t = 0; t < 5; t++) begin
         w = rr_model(4'b1111, exp_last);
         want = N'(1) << w;
         for (int i = 0; i < N; i++) addr_q[i] = rand_addr();
         line = rand_line();
         do_txn(4'b1111, 1, 1'b0, line);
         checks++; if (o_gnt !== want || !$onehot(o_gnt)) begin errors++; $display("FAIL rr_gnt txn %0d got %b want %b", t, o_gnt, want); end
         checks++; if (o_rvalid !== want || o_raddr !== addr_q[w]) begin errors++; $display("FAIL rr_rvalid txn %0d got %b addr %h want %b addr %h", t, o_rvalid, o_raddr, want, addr_q[w]); end
         exp_last = w; exp_rdata = line;
      end
      req = '0;
   endtask

   task automatic test_back_to_back();
      longint prev;
      logic [DATA_W-1:0] line;
      int w;
      prev = 0;
      for (int t = 0; t < 3; t++) begin
         w = rr_model(4'b1111, exp_last);
         for (int i = 0; i < N; i++) addr_q[i] = rand_addr();
         line = rand_line();
         do_txn(4'b1111, 0, 1'b0, line);
         checks++; if (o_gnt !== N'(1) << w) begin errors++; $display("FAIL b2b_gnt got %b want %b", o_gnt, N'(1) << w); end
         if (t > 0) begin
            checks++; if (o_rise - prev != 3) begin errors++; $display("FAIL b2b_spacing got %0d want 3", o_rise - prev); end
         end
         checks++; if (o_rvalid2 !== '0 || o_busy2) begin errors++; $display("FAIL b2b_done rvalid %b busy %b want 0 0", o_rvalid2, o_busy2); end
         prev = o_rise; exp_last = w; exp_rdata = line;
      end
      req = '0;
   endtask

   task automatic test_timeout();
      int k;
      bit seen, rv;
      req = 4'b0100; Rready = 1'b0;
      @(negedge clk);
      checks++; if (gnt !== 4'b0100 || Renable !== 1'b1) begin errors++; $display("FAIL to_grant gnt %b ren %b want 0100 1", gnt, Renable); end
      k = 0; seen = 0; rv = 0;
      while (!seen && k < TO + 100) begin
         @(negedge clk);
         k++;
         rv = rv | (|rvalid);
         if (timeout_err) seen = 1;
      end
      checks++; if (!seen || k != TO + 1) begin errors++; $display("FAIL to_delay seen %0d after %0d want after %0d", seen, k, TO + 1); end
      checks++; if (rv || Renable || gnt !== '0) begin errors++; $display("FAIL to_abort rvalid %b ren %b gnt %b want 0", rv, Renable, gnt); end
      req = '0;
      @(negedge clk);
      checks++; if (timeout_err || busy || rdata !== exp_rdata) begin errors++; $display("FAIL to_after terr %b busy %b rdata %h want 0 0 %h", timeout_err, busy, rdata[63:0], exp_rdata[63:0]); end
      exp_last = 2;
   endtask

   task automatic test_timeout_race();
      logic [DATA_W-1:0] line;
      int w;
      w = rr_model(4'b0010, exp_last);
      for (int i = 0; i < N; i++) addr_q[i] = rand_addr();
      line = rand_line();
      do_txn(4'b0010, TO, 1'b1, line);
      checks++; if (o_rvalid !== N'(1) << w || o_terr) begin errors++; $display("FAIL race_rvalid got %b terr %b want %b 0", o_rvalid, o_terr, N'(1) << w); end
      checks++; if (o_rdata !== line || !o_stable) begin errors++; $display("FAIL race_rdata got %h stable %b want %h", o_rdata[63:0], o_stable, line[63:0]); end
      exp_last = w; exp_rdata = line;
   endtask

   task automatic test_reset_mid_wait();
      logic [DATA_W-1:0] line;
      bit seen;
      int w;
      for (int i = 0; i < N; i++) begin addr_q[i] = rand_addr(); req_addr[i*ADDR_W +: ADDR_W] = addr_q[i]; end
      req = 4'b0010; Rready = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if ({gnt, rvalid, timeout_err, busy, Renable} !== '0 || Raddr !== '0 || rdata !== '0) begin errors++; $display("FAIL rst_async ctrl %b raddr %h want 0", {gnt, rvalid, timeout_err, busy, Renable}, Raddr); end
      addr_q[1] = rand_addr();
      req_addr[ADDR_W +: ADDR_W] = addr_q[1];
      seen = 0;
      repeat (2) begin @(negedge clk); seen = seen | (|rvalid) | timeout_err | Renable | busy; end
      checks++; if (seen) begin errors++; $display("FAIL rst_hold activity %b want 0", seen); end
      rst = 1'b1; exp_last = N - 1; exp_rdata = '0;
      w = rr_model(4'b0010, exp_last);
      @(negedge clk);
      checks++; if (gnt !== N'(1) << w || Raddr !== addr_q[w] || Renable !== 1'b1) begin errors++; $display("FAIL rst_regrant gnt %b addr %h ren %b want %b %h 1", gnt, Raddr, Renable, N'(1) << w, addr_q[w]); end
      line = rand_line();
      Rready = 1'b1; Rdata = line;
      @(negedge clk);
      checks++; if (rvalid !== N'(1) << w || rdata !== line) begin errors++; $display("FAIL rst_complete rvalid %b rdata %h want %b %h", rvalid, rdata[63:0], N'(1) << w, line[63:0]); end
      Rready = 1'b0; req = '0;
      @(negedge clk);
      exp_last = w; exp_rdata = line;
   endtask

   task automatic test_idle_rready();
      bit rv;
      req = '0; Rready = 1'b1; Rdata = rand_line(); rv = 0;
      repeat (3) begin @(negedge clk); rv = rv | (|rvalid) | Renable | busy; end
      Rready = 1'b0;
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL idle_rdata got %h want %h", rdata[63:0], exp_rdata[63:0]); end
      checks++; if (rv) begin errors++; $display("FAIL idle_activity got %b want 0", rv); end
   endtask

   task automatic test_random();
      logic [N-1:0] mask, want;
      logic [DATA_W-1:0] line;
      int w, dly;
      for (int t = 0; t < 20; t++) begin
         mask = N'($urandom_range(1, (1 << N) - 1));
         dly = $urandom_range(0, 5);
         w = rr_model(mask, exp_last);
         want = N'(1) << w;
         for (int i = 0; i < N; i++) addr_q[i] = rand_addr();
         line = rand_line();
         do_txn(mask, dly, 1'b1, line);
         checks++; if (o_gnt !== want || o_raddr !== addr_q[w] || !o_stable) begin errors++; $display("FAIL rand_grant txn %0d gnt %b addr %h stable %b want %b %h 1", t, o_gnt, o_raddr, o_stable, want, addr_q[w]); end
         checks++; if (o_rvalid !== want || o_rdata !== line || o_terr || o_rv_early) begin errors++; $display("FAIL rand_resp txn %0d rvalid %b rdata %h terr %b want %b %h 0", t, o_rvalid, o_rdata[63:0], o_terr, want, line[63:0]); end
         checks++; if (o_rvalid2 !== '0 || o_busy2) begin errors++; $display("FAIL rand_done txn %0d rvalid %b busy %b want 0 0", t, o_rvalid2, o_busy2); end
         exp_last = w; exp_rdata = line;
      end
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_to_back();
      test_timeout();
      test_timeout_race();
      test_reset_mid_wait();
      test_idle_rready();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
